// File: rtl/core_result_serializer.sv
// core_result_serializer
// Per-core output stage: captures one parallel result, optionally emits a
// header beat carrying CORE_ID, then streams the result LSB chunk first as
// DATA_WIDTH beats, flagging the final beat with m_last.
//
// Stream handshake: a beat transfers on a rising clk edge where
// m_valid && m_ready. Once m_valid is high, m_valid/m_data/m_last hold
// until that transfer; m_valid never depends combinationally on m_ready.
// The result side transfers on result_valid && result_ready.
module core_result_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 64,
    parameter int HEADER_EN    = 1,
    parameter int CORE_ID      = 0
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    result_valid,
    output logic                    result_ready,
    input  logic [RESULT_WIDTH-1:0] result_data,
    output logic                    req,
    output logic                    overflow,
    input  logic                    ovf_clear,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [DATA_WIDTH-1:0]   m_data
);

    localparam int PAY_BEATS = RESULT_WIDTH / DATA_WIDTH;
    localparam int BEATS     = PAY_BEATS + ((HEADER_EN != 0) ? 1 : 0);
    localparam int CNT_W     = $clog2(BEATS + 1);

    // Index of the final payload beat in the payload beat counter.
    localparam logic [CNT_W-1:0]      LAST_IDX    = CNT_W'(PAY_BEATS - 1);
    localparam logic [DATA_WIDTH-1:0] HDR_WORD    = DATA_WIDTH'(CORE_ID);
    localparam logic                  SINGLE_BEAT = (PAY_BEATS == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [RESULT_WIDTH-1:0] sr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    m_valid_q;
    logic                    m_last_q;
    logic [DATA_WIDTH-1:0]   m_data_q;
    logic                    ovf_q;
    logic                    ovf_d;

    logic                    beat_hs;
    logic                    frame_done;
    logic                    capture;
    logic                    ovf_set;
    logic [RESULT_WIDTH-1:0] sr_shift;
    logic [CNT_W-1:0]        cnt_inc;

    assign beat_hs      = m_valid_q && m_ready;
    assign frame_done   = beat_hs && m_last_q;
    // Accepting on the last handshake lets frames run back to back.
    assign result_ready = (state_q == ST_IDLE) || frame_done;
    assign capture      = result_valid && result_ready;
    assign ovf_set      = result_valid && !result_ready;
    assign sr_shift     = sr_q >> DATA_WIDTH;
    assign cnt_inc      = cnt_q + CNT_W'(1);

    // Overflow next value: a dropped offer wins over a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end
    end

    // Frame FSM: state, shift register, beat counter and registered stream outputs.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else if (capture) begin
            sr_q      <= result_data;
            cnt_q     <= '0;
            m_valid_q <= 1'b1;
            if (HEADER_EN != 0) begin
                state_q  <= ST_HDR;
                m_data_q <= HDR_WORD;
                m_last_q <= 1'b0;
            end else begin
                state_q  <= ST_PAY;
                m_data_q <= result_data[DATA_WIDTH-1:0];
                m_last_q <= SINGLE_BEAT;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_HDR: begin
                    if (beat_hs) begin
                        state_q  <= ST_PAY;
                        m_data_q <= sr_q[DATA_WIDTH-1:0];
                        m_last_q <= SINGLE_BEAT;
                    end
                end
                ST_PAY: begin
                    if (beat_hs) begin
                        if (m_last_q) begin
                            state_q   <= ST_IDLE;
                            sr_q      <= '0;
                            cnt_q     <= '0;
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            m_data_q  <= '0;
                        end else begin
                            sr_q     <= sr_shift;
                            cnt_q    <= cnt_inc;
                            m_data_q <= sr_shift[DATA_WIDTH-1:0];
                            m_last_q <= (cnt_inc == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    sr_q      <= '0;
                    cnt_q     <= '0;
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                    m_data_q  <= '0;
                end
            endcase
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign m_data   = m_data_q;
    assign req      = m_valid_q;
    assign overflow = ovf_q;

endmodule
